// File: rtl/load_store_unit.sv
// RV32 load/store bridge to the DataMem port: validates a request, issues one masked
// bus command, waits for done and returns extended load data. Optional `LSU_TIMEOUT_EN`.
package MemoryBus;
    typedef struct packed {
        logic        start;
        logic [3:0]  mask_byte;
        logic [31:0] write_data;
    } Cmd;

    typedef struct packed {
        logic        done;
        logic [31:0] data;
    } Result;
endpackage

module load_store_unit #(
    parameter int unsigned WIDTH   = 15,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [2:0]          req_funct3,
    input  logic [31:0]         req_addr,
    input  logic [31:0]         req_wdata,
    output logic                resp_valid,
    output logic                resp_error,
    output logic [31:0]         resp_rdata,
    output logic [WIDTH-3:0]    bus_address,
    output logic                write_enable,
    output MemoryBus::Cmd       membuscmd,
    input  MemoryBus::Result    membusres
);

    localparam int unsigned AW = WIDTH - 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic            write_q, write_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      lane_q, lane_d;
    logic            req_ready_q, req_ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_error_q, resp_error_d;
    logic [31:0]     resp_rdata_q, resp_rdata_d;
    logic [AW-1:0]   bus_address_q, bus_address_d;
    logic            write_enable_q, write_enable_d;
    logic            start_q, start_d;
    logic [3:0]      mask_q, mask_d;
    logic [31:0]     wdata_q, wdata_d;
`ifdef LSU_TIMEOUT_EN
    logic [3:0]      cnt_q, cnt_d;
`else
    logic [3:0]      timeout_unused;
    assign timeout_unused = 4'(TIMEOUT);
`endif

    logic            req_err_c;
    logic [3:0]      mask_c;
    logic [31:0]     load_ext_c;

    // Request validation and byte-lane mask from the raw request
    always_comb begin
        logic funct3_ok;
        logic misalign;
        logic oor;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
            3'b100, 3'b101:         funct3_ok = !req_write;
            default:                funct3_ok = 1'b0;
        endcase
        misalign  = (req_funct3[1:0] == 2'b01 && req_addr[0])
                 || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
        oor       = (req_addr >> WIDTH) != 32'd0;
        req_err_c = !funct3_ok || misalign || oor;
        case (req_funct3[1:0])
            2'b00:   mask_c = 4'b0001 << req_addr[1:0];
            2'b01:   mask_c = req_addr[1] ? 4'b1100 : 4'b0011;
            default: mask_c = 4'b1111;
        endcase
    end

    // Lane select and sign/zero extension of the returned word
    always_comb begin
        logic [7:0]  ld_byte;
        logic [15:0] ld_half;
        ld_byte = 8'(membusres.data >> {lane_q, 3'b000});
        ld_half = lane_q[1] ? membusres.data[31:16] : membusres.data[15:0];
        case (funct3_q)
            3'b000:  load_ext_c = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_ext_c = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_ext_c = {24'd0, ld_byte};
            3'b101:  load_ext_c = {16'd0, ld_half};
            default: load_ext_c = membusres.data;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        write_d        = write_q;
        funct3_d       = funct3_q;
        lane_d         = lane_q;
        resp_valid_d   = 1'b0;
        resp_error_d   = 1'b0;
        resp_rdata_d   = 32'd0;
        bus_address_d  = bus_address_q;
        write_enable_d = write_enable_q;
        start_d        = 1'b0;
        mask_d         = mask_q;
        wdata_d        = wdata_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d          = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    write_d  = req_write;
                    funct3_d = req_funct3;
                    lane_d   = req_addr[1:0];
                    if (req_err_c) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                    end else begin
                        state_d        = S_ISSUE;
                        start_d        = 1'b1;
                        bus_address_d  = req_addr[WIDTH-1:2];
                        write_enable_d = req_write;
                        mask_d         = mask_c;
                        wdata_d        = req_wdata;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef LSU_TIMEOUT_EN
                cnt_d   = 4'd0;
`endif
            end
            S_WAIT: begin
                if (membusres.done) begin
                    state_d = S_CAPTURE;
`ifdef LSU_TIMEOUT_EN
                end else if (cnt_q == 4'(TIMEOUT)) begin
                    state_d        = S_RESP;
                    resp_valid_d   = 1'b1;
                    resp_error_d   = 1'b1;
                    bus_address_d  = '0;
                    write_enable_d = 1'b0;
                    mask_d         = 4'd0;
                    wdata_d        = 32'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
`endif
                end
            end
            S_CAPTURE: begin
                state_d        = S_RESP;
                resp_valid_d   = 1'b1;
                resp_rdata_d   = write_q ? 32'd0 : load_ext_c;
                bus_address_d  = '0;
                write_enable_d = 1'b0;
                mask_d         = 4'd0;
                wdata_d        = 32'd0;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            write_q        <= 1'b0;
            funct3_q       <= 3'd0;
            lane_q         <= 2'd0;
            req_ready_q    <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_error_q   <= 1'b0;
            resp_rdata_q   <= 32'd0;
            bus_address_q  <= '0;
            write_enable_q <= 1'b0;
            start_q        <= 1'b0;
            mask_q         <= 4'd0;
            wdata_q        <= 32'd0;
`ifdef LSU_TIMEOUT_EN
            cnt_q          <= 4'd0;
`endif
        end else begin
            state_q        <= state_d;
            write_q        <= write_d;
            funct3_q       <= funct3_d;
            lane_q         <= lane_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_error_q   <= resp_error_d;
            resp_rdata_q   <= resp_rdata_d;
            bus_address_q  <= bus_address_d;
            write_enable_q <= write_enable_d;
            start_q        <= start_d;
            mask_q         <= mask_d;
            wdata_q        <= wdata_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q          <= cnt_d;
`endif
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_error   = resp_error_q;
    assign resp_rdata   = resp_rdata_q;
    assign bus_address  = bus_address_q;
    assign write_enable = write_enable_q;
    assign membuscmd    = {start_q, mask_q, wdata_q};

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: 4-wait memory model, request-level reference model,
// directed test-plan steps followed by randomized requests.
module tb_load_store_unit;

    localparam int unsigned WIDTH   = 15;
    localparam int unsigned TIMEOUT = 15;
    localparam int unsigned NWORDS  = 1 << (WIDTH - 2);

    logic               clk;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic               req_write;
    logic [2:0]         req_funct3;
    logic [31:0]        req_addr;
    logic [31:0]        req_wdata;
    logic               resp_valid;
    logic               resp_error;
    logic [31:0]        resp_rdata;
    logic [WIDTH-3:0]   bus_address;
    logic               write_enable;
    MemoryBus::Cmd      membuscmd;
    MemoryBus::Result   membusres;

    int n_cmp  = 0;
    int n_fail = 0;

    load_store_unit #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_error  (resp_error),
        .resp_rdata  (resp_rdata),
        .bus_address (bus_address),
        .write_enable(write_enable),
        .membuscmd   (membuscmd),
        .membusres   (membusres)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: done four cycles after start, data one cycle after done
    logic [31:0]  mem     [0:NWORDS-1];
    logic [31:0]  ref_mem [0:NWORDS-1];
    bit           mem_en  = 1'b1;
    int unsigned  n_start = 0;

    initial begin
        int           mcnt;
        bit           pend;
        logic [31:0]  rd_hold;
        logic [12:0]  m_addr;
        logic [3:0]   m_mask;
        logic         m_we;
        logic [31:0]  m_wd;
        mcnt = 0;
        pend = 1'b0;
        rd_hold = 32'd0;
        m_addr = '0; m_mask = '0; m_we = 1'b0; m_wd = '0;
        membusres = '0;
        forever begin
            @(posedge clk);
            #1;
            membusres.done = 1'b0;
            if (pend) begin
                membusres.data = rd_hold;
                pend = 1'b0;
            end
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    membusres.done = 1'b1;
                    if (m_we) begin
                        if (m_mask == 4'b1111)      mem[m_addr] = m_wd;
                        else if (m_mask == 4'b0011) mem[m_addr][15:0] = m_wd[15:0];
                        else if (m_mask == 4'b1100) mem[m_addr][31:16] = m_wd[15:0];
                        else begin
                            for (int i = 0; i < 4; i++)
                                if (m_mask[i]) mem[m_addr][8*i +: 8] = m_wd[7:0];
                        end
                    end
                    rd_hold = mem[m_addr];
                    pend = 1'b1;
                end
            end
            if (membuscmd.start) begin
                n_start++;
                if (mem_en) begin
                    mcnt   = 4;
                    m_addr = bus_address;
                    m_mask = membuscmd.mask_byte;
                    m_we   = write_enable;
                    m_wd   = membuscmd.write_data;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end, expected summary before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: RV32 rules in byte terms; updates ref_mem on stores
    task automatic ref_expect(input bit w, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, output bit err,
                              output logic [31:0] rd, output logic [3:0] mask);
        int unsigned nb, off, idx;
        logic [31:0] v;
        nb  = (f3[1:0] == 2'd3) ? 4 : (1 << f3[1:0]);
        off = a % 4;
        idx = (a / 4) % NWORDS;
        if (w) err = (f3 > 3'd2);
        else   err = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (a % nb != 0) err = 1'b1;
        if (a >= (32'd1 << WIDTH)) err = 1'b1;
        rd = 32'd0;
        mask = 4'd0;
        if (err) return;
        mask = 4'(((1 << nb) - 1) << off);
        if (w) begin
            for (int b = 0; b < int'(nb); b++)
                ref_mem[idx][8*(int'(off)+b) +: 8] = wd[8*b +: 8];
        end else begin
            v = ref_mem[idx] >> (8 * off);
            case (nb)
                1:       rd = f3[2] ? {24'd0, v[7:0]}  : 32'($signed(v[7:0]));
                2:       rd = f3[2] ? {16'd0, v[15:0]} : 32'($signed(v[15:0]));
                default: rd = v;
            endcase
        end
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!req_ready && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, " ready"}, 32'(req_ready), 32'd1);
    endtask

    // One request through the DUT; hang=1 means memory withholds done
    task automatic do_req(input string tag, input bit w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input bit hang,
                          output logic [31:0] got);
        bit          err;
        logic [31:0] exp_rd;
        logic [3:0]  exp_mask;
        int unsigned base;
        int          lat, st_lat, exp_lat;
        logic [3:0]  s_mask;
        logic [31:0] s_ba, s_wd;
        logic        s_we;
        ref_expect(w, f3, a, wd, err, exp_rd, exp_mask);
        if (hang) begin
            exp_rd = 32'd0;
            exp_lat = int'(TIMEOUT) + 3;
        end else begin
            exp_lat = err ? 1 : 7;
        end
        wait_ready(tag);
        base = n_start;
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
        lat = 1; st_lat = 0;
        s_mask = '0; s_ba = '0; s_wd = '0; s_we = 1'b0;
        while (!resp_valid && lat <= 40) begin
            if (membuscmd.start && st_lat == 0) begin
                st_lat = lat;
                s_mask = membuscmd.mask_byte;
                s_ba   = 32'(bus_address);
                s_we   = write_enable;
                s_wd   = membuscmd.write_data;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        got = resp_rdata;
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " error"}, 32'(resp_error), 32'(err || hang));
        check({tag, " rdata"}, resp_rdata, exp_rd);
        if (err) begin
            check({tag, " no start"}, 32'(n_start - base), 32'd0);
        end else begin
            check({tag, " start count"}, 32'(n_start - base), 32'd1);
            check({tag, " start cycle"}, 32'(st_lat), 32'd1);
            check({tag, " mask"}, 32'(s_mask), 32'(exp_mask));
            check({tag, " bus_address"}, s_ba, (a % (32'd1 << WIDTH)) / 4);
            check({tag, " write_enable"}, 32'(s_we), 32'(w));
            if (w) check({tag, " write_data"}, s_wd, wd);
        end
        @(posedge clk);
        #1;
        check({tag, " pulse"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] got;
        int          nresp;
        bit          w;
        logic [2:0]  f3;
        logic [31:0] a;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < int'(NWORDS); i++) begin
            mem[i] = 32'h9E3779B9 * 32'(i);
            ref_mem[i] = mem[i];
        end
        mem[0] = 32'h80FF7F01;
        ref_mem[0] = 32'h80FF7F01;

        rst = 1'b1;
        #1;
        rst = 1'b0;
        #2;
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset outputs", {resp_rdata[31:1], resp_error}, 32'd0);
        check("reset bus", {18'd0, bus_address, write_enable}, 32'd0);
        check("reset cmd", 32'(membuscmd), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset ready", 32'(req_ready), 32'd1);

        do_req("SW 0x10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, got);
        do_req("LB 3", 1'b0, 3'b000, 32'h3, 32'd0, 1'b0, got);
        check("LB 3 literal", got, 32'hFFFFFF80);
        do_req("LBU 3", 1'b0, 3'b100, 32'h3, 32'd0, 1'b0, got);
        check("LBU 3 literal", got, 32'h00000080);
        do_req("LH 2", 1'b0, 3'b001, 32'h2, 32'd0, 1'b0, got);
        check("LH 2 literal", got, 32'hFFFF80FF);
        do_req("LHU 0", 1'b0, 3'b101, 32'h0, 32'd0, 1'b0, got);
        check("LHU 0 literal", got, 32'h00007F01);
        do_req("SH 6", 1'b1, 3'b001, 32'h6, 32'h00001234, 1'b0, got);
        do_req("LW 4", 1'b0, 3'b010, 32'h4, 32'd0, 1'b0, got);
        check("LW 4 upper", {16'd0, got[31:16]}, 32'h1234);
        do_req("err LW 2", 1'b0, 3'b010, 32'h2, 32'd0, 1'b0, got);
        do_req("err LH 1", 1'b0, 3'b001, 32'h1, 32'd0, 1'b0, got);
        do_req("err f3 011", 1'b0, 3'b011, 32'h20, 32'd0, 1'b0, got);
        do_req("err SW f3 100", 1'b1, 3'b100, 32'h20, 32'd0, 1'b0, got);
        do_req("err addr 0x8000", 1'b0, 3'b010, 32'h8000, 32'd0, 1'b0, got);

        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
            else if (w) f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
            end
            a = 32'h100 + 32'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(WIDTH, 31));
            do_req($sformatf("rand%0d", i), w, f3, a, $urandom, 1'b0, got);
        end

        // Reset during WAIT drops the transaction silently
        wait_ready("rst-mid");
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mid-reset ready", 32'(req_ready), 32'd0);
        check("mid-reset resp", {29'd0, resp_valid, resp_error, |resp_rdata}, 32'd0);
        check("mid-reset bus", {18'd0, bus_address, write_enable}, 32'd0);
        check("mid-reset cmd", 32'(membuscmd), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid-reset release ready", 32'(req_ready), 32'd1);
        nresp = 0;
        repeat (12) begin
            if (resp_valid) nresp++;
            @(posedge clk);
            #1;
        end
        check("mid-reset no response", 32'(nresp), 32'd0);

        mem_en = 1'b0;
`ifdef LSU_TIMEOUT_EN
        do_req("timeout LW", 1'b0, 3'b010, 32'h40, 32'd0, 1'b1, got);
`else
        wait_ready("hang");
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        nresp = 0;
        repeat (100) begin
            if (resp_valid) nresp++;
            @(posedge clk);
            #1;
        end
        check("hang no response", 32'(nresp), 32'd0);
        check("hang ready low", 32'(req_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
`endif
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Bridges the core's execute stage to the `DataMem` data-memory port. It accepts one RV32 load/store request at a time and checks alignment, funct3 and range. It issues a single `MemoryBus::Cmd` with byte lanes, word address and write enable, waits for `done`, then extracts and sign/zero-extends load data into a one-cycle response.

## Interface
- `WIDTH`, 15: byte-address width of data memory; word address is `WIDTH-2` bits.
- `TIMEOUT`, 15: max cycles waiting for `done` (used only with `LSU_TIMEOUT_EN`).

Ports:
- `clk`  input  1  clock; one clock domain.
- `rst`  input  1  reset, asynchronous, active-low.
- `req_valid`  input  1  request present.
- `req_ready`  output  1  high only in IDLE and with `rst` high.
- `req_write`  input  1  1 = store, 0 = load.
- `req_funct3`  input  3  RV32 width/sign code.
- `req_addr`  input  32  byte address.
- `req_wdata`  input  32  store data, right-aligned.
- `resp_valid`  output  1  one-cycle response pulse; no backpressure.
- `resp_error`  output  1  request rejected or aborted.
- `resp_rdata`  output  32  extended load data; 0 for stores and errors.
- `bus_address`  output  WIDTH-2  word address to data memory.
- `write_enable`  output  1  store qualifier.
- `membuscmd`  output  MemoryBus::Cmd  `start`, `mask_byte`, `write_data`; unused fields 0.
- `membusres`  input  MemoryBus::Result  `done`, `data`.

## Operation
- States: IDLE, ISSUE, WAIT, CAPTURE, RESP.
- IDLE: on `req_valid && req_ready`, register request, validate, and go to ISSUE, or to RESP with error.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000, 001, 010.
  - Anything else is an error.
- Other errors:
  - Misaligned: halfword with `addr[0]=1`; word with `addr[1:0]!=0`.
  - Out of range: any `req_addr[31:WIDTH]` nonzero.
- Error path: no bus activity; `resp_error=1`, `resp_rdata=0`.
- Byte-lane mask:
  - Byte: `1<<addr[1:0]`.
  - Half: `addr[1] ? 1100 : 0011`.
  - Word: `1111`.
- `write_data` is `req_wdata` unshifted. The memory routes its low byte/halfword to the masked lane.
- `bus_address = addr[WIDTH-1:2]`. It and `write_enable` are held constant from ISSUE until leaving CAPTURE.
- ISSUE: `start=1` for exactly one cycle, then WAIT.
- WAIT: stay until `membusres.done=1`, then CAPTURE.
- CAPTURE: sample `membusres.data`, which is valid the cycle after `done`.
  - Loads: select byte/half by `addr[1:0]`; sign-extend LB/LH, zero-extend LBU/LHU.
  - Stores: `resp_rdata=0`.
  - Then go to RESP.
- RESP: `resp_valid=1` for one cycle, then IDLE.
- `start` never asserts outside ISSUE, which guarantees no re-trigger of the memory.

## Timing
- Reset values (async, while `rst` low): state IDLE, `req_ready=0`, `resp_valid=0`, `resp_error=0`, `resp_rdata=0`, `bus_address=0`, `write_enable=0`, `membuscmd=0`.
- Reset mid-transaction drops it silently; no response follows.
- Timeline with accept at cycle 0:
  - `start` high in cycle 1.
  - `done` seen in cycle N: CAPTURE at N+1, `resp_valid` at N+2.
  - With the standard 4-wait memory (`done` in cycle 5): `resp_valid` in cycle 7.
- Error response: `resp_valid` in cycle 1.
- Next request is accepted in the cycle after RESP; no back-to-back overlap.
- `done` seen in the same cycle as ISSUE is ignored; it counts only in WAIT.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - A 4-bit counter clears at ISSUE and increments each WAIT cycle.
  - When it reaches `TIMEOUT` without `done`: go to RESP with `resp_error=1`, `resp_rdata=0`.
  - A late `done` arriving in IDLE is ignored.
- Undefined: WAIT blocks indefinitely; no counter is synthesized.

## Test plan
- SW addr 0x10, data 0xDEADBEEF -> `start` pulse cycle 1, `mask_byte=1111`, `bus_address=4`, `write_enable=1`, `resp_valid` cycle 7, `resp_error=0`.
- Memory word 0x80FF7F01:
  - LB addr 3 -> 0xFFFFFF80.
  - LBU addr 3 -> 0x00000080.
  - LH addr 2 -> 0xFFFF80FF.
  - LHU addr 0 -> 0x00007F01.
- SH addr 0x6, data 0x1234 -> `mask_byte=1100`, `write_data[15:0]=0x1234`; a following LW addr 0x4 returns 0x1234xxxx.
- Error requests -> `resp_valid` cycle 1, `resp_error=1`, `start` never asserts:
  - LW addr 0x2.
  - LH addr 0x1.
  - funct3=011.
  - addr 0x8000 with WIDTH=15.
- Assert `rst` low during WAIT -> all outputs 0 immediately; after release `req_ready=1`, no `resp_valid`.
- With `LSU_TIMEOUT_EN`, memory never asserts `done` -> `resp_valid` with `resp_error=1` exactly TIMEOUT+2 cycles after `start`; without it, no response for 100 cycles.
